tx_os_scheduler: RTL and testbench
==================================

// Module: tx_os_scheduler
// PURPOSE
//  Schedules the shared TX path (OS generator + data/OS mux) between three requesters:
//  periodic SKP insertion, ordered-set requests from TX LTSSM, and LPIF data FIFO.
//  Sits between TX LTSSM / LPIF FIFO and the OS generator; owns MuxSel, HoldFIFOData,
//  OSGeneratorStart and OSType. Switches away from data only at packet boundaries.
// PARAMETERS
//  SKP_INTERVAL  1180  Pclk cycles between SKP insertions while LinkUp=1 (>=2)
//  OS_TIMEOUT    256   max Pclk cycles from start pulse to OSGeneratorFinish
//  CNT_W         16    width of SKP and timeout counters (2^CNT_W > both params)
// PORTS
//  Pclk              in   1  clock
//  Reset             in   1  synchronous, active-low
//  LinkUp            in   1  1 = LTSSM in L0; enables SKP timer and data grants
//  OSReq             in   1  level; LTSSM requests one OS, held until OSAck
//  OSReqType         in   2  00 TS1, 01 TS2, 10 IDLE (11 reserved, treated as IDLE)
//  OSAck             out  1  1-cycle pulse: requested OS completed
//  FIFOReady         in   1  LPIF FIFO has data
//  DataBoundary      in   1  current data beat ends a packet (safe switch point)
//  HoldFIFOData      out  1  1 = FIFO must not advance
//  MuxSel            out  1  1 = data path, 0 = OS generator path
//  OSGeneratorStart  out  1  1-cycle start pulse
//  OSType            out  2  OS type for generator; 11 = SKP
//  OSGeneratorBusy   in   1  generator busy
//  OSGeneratorFinish in   1  1-cycle pulse: OS fully sent
//  SkpMissed         out  1  1-cycle pulse: SKP interval expired while SKP already pending
//  OSTimeoutErr      out  1  1-cycle pulse: generator did not finish within OS_TIMEOUT
// BEHAVIOUR
//  Reset (Reset=0 at Pclk edge, any state): state IDLE, HoldFIFOData=1, MuxSel=0,
//   OSGeneratorStart=0, OSType=00, OSAck=0, SkpMissed=0, OSTimeoutErr=0,
//   SKP counter=0, SkpPending=0, timeout counter=0. All outputs registered.
//  SKP timer: counts while LinkUp=1; at SKP_INTERVAL-1 wraps to 0 and sets SkpPending;
//   if SkpPending already 1 -> SkpMissed pulse, pending stays 1 (no queue).
//   LinkUp=0: counter and SkpPending cleared. Issue of the SKP start clears SkpPending.
//  Priority at each decision point: SKP (pending & LinkUp) > OSReq > data (FIFOReady & LinkUp).
//  States:
//   IDLE   : Hold=1, MuxSel=0. If any OS source wins and !OSGeneratorBusy -> ISSUE;
//            else if data eligible -> DATA. Busy=1 keeps IDLE.
//   ISSUE  : one cycle; OSGeneratorStart=1, OSType latched (11 for SKP, else OSReqType),
//            source latched; -> WAIT. Timeout counter cleared.
//   WAIT   : Hold=1, MuxSel=0; timeout counter increments. On OSGeneratorFinish:
//            OSAck pulse next cycle if source was OSReq; -> IDLE.
//            Counter reaches OS_TIMEOUT without Finish: OSTimeoutErr pulse, no OSAck, -> IDLE.
//   DATA   : MuxSel=1, Hold=0. Leave to IDLE (Hold=1 same cycle as transition) when
//            DataBoundary=1 and (SkpPending | OSReq | !FIFOReady), or immediately when LinkUp=0.
//  Latency: IDLE with pending OS and idle generator -> start pulse 2 Pclk later.
//  Finish outside WAIT ignored. OSReq dropped before grant: no OSAck, no OS issued.
//  Finish and timeout in same cycle: Finish wins (no error).
//  Simultaneous SKP expiry and SKP issue: SkpPending stays 1 (new interval), no SkpMissed.
//  OSReq and SKP pending together: SKP first, then OSReq on next IDLE pass; no starvation
//   since SKP rate bounded by SKP_INTERVAL.
// TESTING
//  1 LinkUp=1, FIFOReady=1, DataBoundary every 8 cycles, SKP_INTERVAL=64 -> MuxSel drops
//    only on a boundary, one start with OSType=11 per 64 cycles, data resumes after Finish.
//  2 LinkUp=0, OSReq=1 type 01, Finish 20 cycles after start -> one start with OSType=01,
//    OSAck exactly 1 cycle after Finish, MuxSel stays 0, Hold stays 1.
//  3 SKP pending and OSReq asserted same cycle -> SKP (11) issued first, then OSReq type;
//    exactly two starts, one OSAck.
//  4 Generator never finishes, OS_TIMEOUT=256 -> OSTimeoutErr pulse 256 cycles after
//    ISSUE, no OSAck, return to IDLE and reissue if OSReq still high.
//  5 Data streaming with DataBoundary=0 for 3*SKP_INTERVAL -> SkpMissed pulses at 2nd
//    and 3rd expiry; single SKP issued at next boundary.
//  6 Reset=0 asserted in WAIT and in DATA -> next cycle all outputs at reset values,
//    late Finish after release ignored.

Source files
------------

// File: rtl/tx_os_scheduler_if.sv
`default_nettype none
// ============================================================================
// tx_os_scheduler_if : TX LTSSM / LPIF FIFO / OS generator signals of the scheduler
// Rev 1.0
// ============================================================================
interface tx_os_scheduler_if;
    logic       LinkUp;
    logic       OSReq;
    logic [1:0] OSReqType;
    logic       OSAck;
    logic       FIFOReady;
    logic       DataBoundary;
    logic       HoldFIFOData;
    logic       MuxSel;
    logic       OSGeneratorStart;
    logic [1:0] OSType;
    logic       OSGeneratorBusy;
    logic       OSGeneratorFinish;
    logic       SkpMissed;
    logic       OSTimeoutErr;

    modport master (
        input  LinkUp, OSReq, OSReqType, FIFOReady, DataBoundary,
               OSGeneratorBusy, OSGeneratorFinish,
        output OSAck, HoldFIFOData, MuxSel, OSGeneratorStart, OSType,
               SkpMissed, OSTimeoutErr
    );

    modport slave (
        output LinkUp, OSReq, OSReqType, FIFOReady, DataBoundary,
               OSGeneratorBusy, OSGeneratorFinish,
        input  OSAck, HoldFIFOData, MuxSel, OSGeneratorStart, OSType,
               SkpMissed, OSTimeoutErr
    );
endinterface
`default_nettype wire

// File: rtl/tx_os_scheduler.sv
`default_nettype none
// ============================================================================
// tx_os_scheduler : arbitrates SKP / LTSSM ordered sets / FIFO data on the TX path
// Rev 1.0
// ============================================================================
module tx_os_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int OS_TIMEOUT   = 256,
    parameter int CNT_W        = 16
) (
    input  wire logic         Pclk,
    input  wire logic         Reset,
    tx_os_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(OS_TIMEOUT - 1);
    localparam logic [1:0]       OS_SKP   = 2'b11;
    localparam logic [1:0]       OS_IDLE  = 2'b10;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             skp_pend_q, skp_pend_d;
    logic             src_req_q, src_req_d;
    logic [1:0]       os_type_q, os_type_d;
    logic             hold_q, hold_d;
    logic             mux_q, mux_d;
    logic             start_q, start_d;
    logic             ack_q, ack_d;
    logic             missed_q, missed_d;
    logic             err_q, err_d;
    logic             skp_win, req_win, skp_issue, skp_expire;

    always_comb begin
        state_d    = state_q;
        os_type_d  = os_type_q;
        src_req_d  = src_req_q;
        tmo_cnt_d  = tmo_cnt_q;
        skp_cnt_d  = skp_cnt_q;
        skp_pend_d = skp_pend_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        skp_issue  = 1'b0;
        skp_win    = skp_pend_q & bus.LinkUp;
        // A request still high while its own OSAck is out belongs to the finished OS.
        req_win    = bus.OSReq & ~ack_q;

        case (state_q)
            ST_IDLE: begin
                if (skp_win | req_win) begin
                    if (!bus.OSGeneratorBusy) begin
                        state_d   = ST_ISSUE;
                        skp_issue = skp_win;
                        src_req_d = ~skp_win;
                        os_type_d = skp_win ? OS_SKP :
                                    (bus.OSReqType == OS_SKP) ? OS_IDLE : bus.OSReqType;
                    end
                end else if (bus.FIFOReady & bus.LinkUp) begin
                    state_d = ST_DATA;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                tmo_cnt_d = '0;
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (bus.OSGeneratorFinish) begin
                    state_d = ST_IDLE;
                    ack_d   = src_req_q;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_DATA: begin
                if (!bus.LinkUp ||
                    (bus.DataBoundary && (skp_pend_q || bus.OSReq || !bus.FIFOReady))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An expiry coinciding with an SKP issue opens a fresh interval rather than a miss.
        skp_expire = bus.LinkUp & (skp_cnt_q == SKP_LAST);
        missed_d   = skp_expire & skp_pend_q & ~skp_issue;
        if (!bus.LinkUp) begin
            skp_cnt_d  = '0;
            skp_pend_d = 1'b0;
        end else begin
            skp_cnt_d  = skp_expire ? '0 : skp_cnt_q + 1'b1;
            skp_pend_d = skp_expire | (skp_pend_q & ~skp_issue);
        end

        hold_d  = (state_d != ST_DATA);
        mux_d   = (state_d == ST_DATA);
        start_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            skp_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            skp_pend_q <= 1'b0;
            src_req_q  <= 1'b0;
            os_type_q  <= 2'b00;
            hold_q     <= 1'b1;
            mux_q      <= 1'b0;
            start_q    <= 1'b0;
            ack_q      <= 1'b0;
            missed_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            skp_cnt_q  <= skp_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            skp_pend_q <= skp_pend_d;
            src_req_q  <= src_req_d;
            os_type_q  <= os_type_d;
            hold_q     <= hold_d;
            mux_q      <= mux_d;
            start_q    <= start_d;
            ack_q      <= ack_d;
            missed_q   <= missed_d;
            err_q      <= err_d;
        end
    end

    assign bus.OSAck            = ack_q;
    assign bus.HoldFIFOData     = hold_q;
    assign bus.MuxSel           = mux_q;
    assign bus.OSGeneratorStart = start_q;
    assign bus.OSType           = os_type_q;
    assign bus.SkpMissed        = missed_q;
    assign bus.OSTimeoutErr     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_tx_os_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tx_os_scheduler : random LTSSM / FIFO / generator traffic against a reference model
// Rev 1.0
// ============================================================================
module tb_tx_os_scheduler;
    localparam int         SKP_INTERVAL = 64;
    localparam int         OS_TIMEOUT   = 40;
    localparam int         N_CYCLES     = 12000;
    localparam logic [7:0] RST_VEC      = 8'b1000_0000;

    logic Pclk = 1'b0;
    logic Reset;
    always #5 Pclk = ~Pclk;

    tx_os_scheduler_if bus ();

    tx_os_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .OS_TIMEOUT   (OS_TIMEOUT),
        .CNT_W        (16)
    ) dut (
        .Pclk  (Pclk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0b expected=%0b", tag, $time, got, exp);
        end
    endtask

    // Reference model: link timer age, owed SKP, and what the TX path is doing.
    int         m_skp_age = 0;
    bit         m_skp_owed = 0;
    bit         m_stream = 0, m_issue = 0, m_wait = 0, m_for_req = 0;
    int         m_elapsed = 0;
    logic [1:0] e_type = 2'b00;
    bit         e_ack = 0, e_err = 0, e_missed = 0;
    bit         rst_seen = 0;

    int gen_left = 0;
    bit req_drop_next = 0, req_en = 1;
    int lu_down_left = 0;
    bit rst_wait_done = 0, rst_data_done = 0;

    function automatic logic [7:0] dut_outs();
        return {bus.HoldFIFOData, bus.MuxSel, bus.OSGeneratorStart, bus.OSType,
                bus.OSAck, bus.OSTimeoutErr, bus.SkpMissed};
    endfunction

    function automatic logic [7:0] exp_outs();
        return {~m_stream, m_stream, m_issue, e_type, e_ack, e_err, e_missed};
    endfunction

    task automatic model_step();
        bit ack_now, owed_now, skp_grant, expired;
        ack_now   = e_ack;
        owed_now  = m_skp_owed;
        skp_grant = 1'b0;
        e_ack = 0; e_err = 0; e_missed = 0;
        rst_seen = !Reset;
        if (!Reset) begin
            m_skp_age = 0; m_skp_owed = 0; m_stream = 0; m_issue = 0;
            m_wait = 0; m_elapsed = 0; m_for_req = 0; e_type = 2'b00;
            return;
        end
        if (m_issue) begin
            m_issue = 0; m_wait = 1; m_elapsed = 0;
        end else if (m_wait) begin
            m_elapsed++;
            if (bus.OSGeneratorFinish) begin
                m_wait = 0; e_ack = m_for_req;
            end else if (m_elapsed == OS_TIMEOUT) begin
                m_wait = 0; e_err = 1;
            end
        end else if (m_stream) begin
            if (!bus.LinkUp || (bus.DataBoundary && (owed_now || bus.OSReq || !bus.FIFOReady)))
                m_stream = 0;
        end else if ((owed_now && bus.LinkUp) || (bus.OSReq && !ack_now)) begin
            if (!bus.OSGeneratorBusy) begin
                skp_grant = owed_now && bus.LinkUp;
                m_issue   = 1;
                m_for_req = !skp_grant;
                e_type    = skp_grant ? 2'b11 : (bus.OSReqType == 2'b11 ? 2'b10 : bus.OSReqType);
            end
        end else if (bus.FIFOReady && bus.LinkUp) begin
            m_stream = 1;
        end
        if (!bus.LinkUp) begin
            m_skp_age = 0; m_skp_owed = 0;
        end else begin
            expired   = (m_skp_age == SKP_INTERVAL - 1);
            m_skp_age = expired ? 0 : m_skp_age + 1;
            if (expired) begin
                e_missed   = owed_now && !skp_grant;
                m_skp_owed = 1;
            end else if (skp_grant) begin
                m_skp_owed = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge Pclk);
        model_step();
        #1;
        check_eq("outs", dut_outs(), exp_outs());
        if (rst_seen) check_eq("reset_outs", dut_outs(), RST_VEC);
    endtask

    task automatic drive(input int c);
        // OS generator: finishes 1..OS_TIMEOUT+8 cycles after start, sometimes too late.
        bus.OSGeneratorFinish = 1'b0;
        if (bus.OSGeneratorStart) begin
            gen_left = int'($urandom_range(OS_TIMEOUT + 8, 1));
        end else if (gen_left > 0) begin
            gen_left--;
            if (gen_left == 0) bus.OSGeneratorFinish = 1'b1;
        end else if ($urandom_range(31, 0) == 0) begin
            bus.OSGeneratorFinish = 1'b1;
        end
        bus.OSGeneratorBusy = (gen_left > 0) || ($urandom_range(15, 0) == 0);

        if (bus.OSReq) begin
            if (req_drop_next) begin
                bus.OSReq = 1'b0; req_drop_next = 0;
            end else if (bus.OSAck) begin
                req_drop_next = 1;
            end else if ($urandom_range(99, 0) == 0) begin
                bus.OSReq = 1'b0;
            end
        end else if (req_en && $urandom_range(24, 0) == 0) begin
            bus.OSReq     = 1'b1;
            bus.OSReqType = 2'($urandom_range(3, 0));
        end

        if (c >= 4000 && c < 4400) begin
            req_en = 0;
            bus.LinkUp = 1'b1; bus.FIFOReady = 1'b1; bus.DataBoundary = 1'b0;
        end else if (c >= 4400 && c < 4800) begin
            req_en = 1;
            bus.LinkUp = 1'b0;
            bus.FIFOReady    = ($urandom_range(7, 0) != 0);
            bus.DataBoundary = ($urandom_range(7, 0) == 0);
        end else begin
            req_en = 1;
            if (lu_down_left > 0) lu_down_left--;
            else if ($urandom_range(399, 0) == 0) lu_down_left = int'($urandom_range(30, 1));
            bus.LinkUp       = (lu_down_left == 0);
            bus.FIFOReady    = ($urandom_range(7, 0) != 0);
            bus.DataBoundary = ($urandom_range(7, 0) == 0);
        end

        Reset = 1'b1;
        if (c > 2000 && !rst_wait_done && gen_left > 3 && !bus.OSGeneratorStart) begin
            Reset = 1'b0; rst_wait_done = 1;
        end else if (c > 3000 && !rst_data_done && bus.MuxSel) begin
            Reset = 1'b0; rst_data_done = 1;
        end
    endtask

    initial begin
        Reset = 1'b0;
        bus.LinkUp = 1'b0; bus.OSReq = 1'b0; bus.OSReqType = 2'b00;
        bus.FIFOReady = 1'b0; bus.DataBoundary = 1'b0;
        bus.OSGeneratorBusy = 1'b0; bus.OSGeneratorFinish = 1'b0;
        repeat (3) step();
        Reset = 1'b1;
        for (int c = 0; c < N_CYCLES; c++) begin
            step();
            drive(c);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
